// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding, load-use stall detection
// and bubble insertion; drives the ALU operands and opcode directly.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_alu_control,
    input  logic              id_alu_src_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              mw_reg_write,
    input  logic [REG_AW-1:0] mw_rd,
    input  logic [XLEN-1:0]   mw_result,
    output logic              stall_ifid,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [CTRL_W-1:0] alu_control,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    logic              valid_q,       valid_d;
    logic [XLEN-1:0]   pc_q,          pc_d;
    logic [REG_AW-1:0] rs1_addr_q,    rs1_addr_d;
    logic [REG_AW-1:0] rs2_addr_q,    rs2_addr_d;
    logic [REG_AW-1:0] rd_q,          rd_d;
    logic [XLEN-1:0]   rs1_data_q,    rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q,    rs2_data_d;
    logic [XLEN-1:0]   imm_q,         imm_d;
    logic [CTRL_W-1:0] alu_control_q, alu_control_d;
    logic              alu_src_imm_q, alu_src_imm_d;
    logic              reg_write_q,   reg_write_d;
    logic              mem_read_q,    mem_read_d;
    logic              mem_write_q,   mem_write_d;

    logic              bubble;
    logic              rs1_hit;
    logic              rs2_hit;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;

    // EX/MEM beats MEM/WB because it holds the younger write to the same register.
    function automatic logic [XLEN-1:0] forward_src(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   reg_val,
        input logic              exm_we,
        input logic [REG_AW-1:0] exm_dst,
        input logic [XLEN-1:0]   exm_val,
        input logic              mw_we,
        input logic [REG_AW-1:0] mw_dst,
        input logic [XLEN-1:0]   mw_val
    );
        logic [XLEN-1:0] sel;
        sel = reg_val;
        if (rs != '0) begin
            if (exm_we && (exm_dst == rs)) begin
                sel = exm_val;
            end else if (mw_we && (mw_dst == rs)) begin
                sel = mw_val;
            end
        end
        return sel;
    endfunction

    // A load in EX cannot forward until MEM/WB, so a dependent ID instruction must wait one cycle.
    always_comb begin
        rs1_hit    = (rd_q == id_rs1_addr);
        rs2_hit    = (rd_q == id_rs2_addr) && (!id_alu_src_imm || id_mem_write);
        stall_ifid = id_valid && valid_q && mem_read_q && (rd_q != '0) && (rs1_hit || rs2_hit);
        bubble     = flush || stall_ifid;
    end

    always_comb begin
        // Payload fields follow ID every cycle; a bubble is defined by the cleared control bits.
        pc_d          = id_pc;
        rs1_addr_d    = id_rs1_addr;
        rs2_addr_d    = id_rs2_addr;
        rd_d          = id_rd_addr;
        rs1_data_d    = id_rs1_data;
        rs2_data_d    = id_rs2_data;
        imm_d         = id_imm;
        alu_src_imm_d = id_alu_src_imm;
        valid_d       = id_valid;
        alu_control_d = id_alu_control;
        reg_write_d   = id_reg_write && id_valid;
        mem_read_d    = id_mem_read  && id_valid;
        mem_write_d   = id_mem_write && id_valid;
        if (bubble) begin
            valid_d       = 1'b0;
            alu_control_d = '0;
            reg_write_d   = 1'b0;
            mem_read_d    = 1'b0;
            mem_write_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            pc_q          <= '0;
            rs1_addr_q    <= '0;
            rs2_addr_q    <= '0;
            rd_q          <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            alu_control_q <= '0;
            alu_src_imm_q <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            pc_q          <= pc_d;
            rs1_addr_q    <= rs1_addr_d;
            rs2_addr_q    <= rs2_addr_d;
            rd_q          <= rd_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            imm_q         <= imm_d;
            alu_control_q <= alu_control_d;
            alu_src_imm_q <= alu_src_imm_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
        end
    end

    // EX stage: operand selection on registered sources
    always_comb begin
        fwd_rs1 = forward_src(rs1_addr_q, rs1_data_q, exm_reg_write, exm_rd, exm_result,
                              mw_reg_write, mw_rd, mw_result);
        fwd_rs2 = forward_src(rs2_addr_q, rs2_data_q, exm_reg_write, exm_rd, exm_result,
                              mw_reg_write, mw_rd, mw_result);
        alu_a         = fwd_rs1;
        alu_b         = alu_src_imm_q ? imm_q : fwd_rs2;
        ex_store_data = fwd_rs2;
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign alu_control  = alu_control_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_mem_write = mem_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Vector-table bench for id_ex_stage: each record drives ID and forwarding inputs and
// queues the EX-side values expected one clock later.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [5:0]  id_alu_control;
    logic        id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        mw_reg_write;
    logic [4:0]  mw_rd;
    logic [31:0] mw_result;
    logic        stall_ifid, ex_valid;
    logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
    logic [5:0]  alu_control;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    int errors = 0;
    int checks = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_control(id_alu_control), .id_alu_src_imm(id_alu_src_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mw_reg_write(mw_reg_write), .mw_rd(mw_rd), .mw_result(mw_result),
        .stall_ifid(stall_ifid), .ex_valid(ex_valid), .ex_pc(ex_pc), .alu_a(alu_a),
        .alu_b(alu_b), .alu_control(alu_control), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [5:0]  ctrl;
        logic        src, rw, mr, mw, flush;
        logic        exm_rw;
        logic [4:0]  exm_rd;
        logic [31:0] exm_res;
        logic        mw_rw;
        logic [4:0]  mw_rd;
        logic [31:0] mw_res;
        logic        e_stall, e_valid;
        logic [31:0] e_a, e_b, e_store, e_pc;
        logic [5:0]  e_ctrl;
        logic        e_rw, e_mr, e_mw;
        logic [4:0]  e_rd;
        logic        chk;
    } vec_t;

    vec_t vecs[17];
    vec_t sb[$];

    function automatic vec_t mk_id(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                                   input logic [31:0] imm, input logic [5:0] ctrl, input logic src,
                                   input logic rw, input logic mr, input logic mw, input logic fl);
        vec_t v;
        v = '{default: '0};
        v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.d1 = d1; v.d2 = d2; v.imm = imm; v.ctrl = ctrl;
        v.src = src; v.rw = rw; v.mr = mr; v.mw = mw; v.flush = fl;
        return v;
    endfunction

    function automatic vec_t with_fwd(input vec_t vi, input logic erw, input logic [4:0] erd,
                                      input logic [31:0] eres, input logic mrw,
                                      input logic [4:0] mrd, input logic [31:0] mres);
        vec_t v;
        v = vi;
        v.exm_rw = erw; v.exm_rd = erd; v.exm_res = eres;
        v.mw_rw = mrw; v.mw_rd = mrd; v.mw_res = mres;
        return v;
    endfunction

    function automatic vec_t with_exp(input vec_t vi, input logic stall, input logic valid,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] st, input logic [5:0] ctrl,
                                      input logic rw, input logic mr, input logic mw,
                                      input logic [4:0] rd, input logic chk);
        vec_t v;
        v = vi;
        v.e_stall = stall; v.e_valid = valid; v.e_a = a; v.e_b = b; v.e_store = st;
        v.e_ctrl = ctrl; v.e_rw = rw; v.e_mr = mr; v.e_mw = mw; v.e_rd = rd; v.chk = chk;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input logic [31:0] pc);
        flush = v.flush; id_valid = v.valid; id_pc = pc;
        id_rs1_addr = v.rs1; id_rs2_addr = v.rs2; id_rd_addr = v.rd;
        id_rs1_data = v.d1; id_rs2_data = v.d2; id_imm = v.imm;
        id_alu_control = v.ctrl; id_alu_src_imm = v.src;
        id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw;
        exm_reg_write = v.exm_rw; exm_rd = v.exm_rd; exm_result = v.exm_res;
        mw_reg_write = v.mw_rw; mw_rd = v.mw_rd; mw_result = v.mw_res;
    endtask

    task automatic compare_ex(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, ".ex_valid"},     {31'd0, ex_valid},     {31'd0, e.e_valid});
        check({tag, ".alu_control"},  {26'd0, alu_control},  {26'd0, e.e_ctrl});
        check({tag, ".ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, e.e_rw});
        check({tag, ".ex_mem_read"},  {31'd0, ex_mem_read},  {31'd0, e.e_mr});
        check({tag, ".ex_mem_write"}, {31'd0, ex_mem_write}, {31'd0, e.e_mw});
        if (e.chk) begin
            check({tag, ".alu_a"},         alu_a,         e.e_a);
            check({tag, ".alu_b"},         alu_b,         e.e_b);
            check({tag, ".ex_store_data"}, ex_store_data, e.e_store);
            check({tag, ".ex_rd"},         {27'd0, ex_rd}, {27'd0, e.e_rd});
            check({tag, ".ex_pc"},         ex_pc,         e.e_pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        // ID instruction, forwarding inputs, then expected EX outputs after one edge
        vecs[0]  = with_exp(mk_id(1, 1, 0, 2, 32'h5, 32'h9, 32'h7, 6'd1, 1, 1, 0, 0, 0),
                            0, 1, 32'h5, 32'h7, 32'h9, 6'd1, 1, 0, 0, 5'd2, 1);
        vecs[1]  = with_exp(with_fwd(mk_id(1, 3, 0, 6, 32'h99, 32'h44, 32'h0, 6'd2, 0, 1, 0, 0, 0),
                                     1, 3, 32'h10, 1, 3, 32'h20),
                            0, 1, 32'h10, 32'h44, 32'h44, 6'd2, 1, 0, 0, 5'd6, 1);
        vecs[2]  = with_exp(with_fwd(mk_id(1, 3, 0, 6, 32'h99, 32'h44, 32'h0, 6'd2, 0, 1, 0, 0, 0),
                                     0, 3, 32'h10, 1, 3, 32'h20),
                            0, 1, 32'h20, 32'h44, 32'h44, 6'd2, 1, 0, 0, 5'd6, 1);
        vecs[3]  = with_exp(with_fwd(mk_id(1, 0, 0, 6, 32'h55, 32'h66, 32'h0, 6'd3, 0, 1, 0, 0, 0),
                                     1, 0, 32'h10, 1, 0, 32'h20),
                            0, 1, 32'h55, 32'h66, 32'h66, 6'd3, 1, 0, 0, 5'd6, 1);
        vecs[4]  = with_exp(mk_id(1, 1, 0, 4, 32'h100, 32'h0, 32'h4, 6'd1, 1, 1, 1, 0, 0),
                            0, 1, 32'h100, 32'h4, 32'h0, 6'd1, 1, 1, 0, 5'd4, 1);
        vecs[5]  = with_exp(mk_id(1, 5, 4, 7, 32'h1, 32'h2, 32'h0, 6'd1, 0, 1, 0, 0, 0),
                            1, 0, 32'h0, 32'h0, 32'h0, 6'd0, 0, 0, 0, 5'd0, 0);
        vecs[6]  = with_exp(with_fwd(mk_id(1, 5, 4, 7, 32'h1, 32'h2, 32'h0, 6'd1, 0, 1, 0, 0, 0),
                                     0, 0, 32'h0, 1, 4, 32'h777),
                            0, 1, 32'h1, 32'h777, 32'h777, 6'd1, 1, 0, 0, 5'd7, 1);
        vecs[7]  = with_exp(mk_id(1, 0, 0, 8, 32'h200, 32'h0, 32'h0, 6'd1, 1, 1, 1, 0, 0),
                            0, 1, 32'h200, 32'h0, 32'h0, 6'd1, 1, 1, 0, 5'd8, 1);
        vecs[8]  = with_exp(mk_id(1, 0, 8, 0, 32'h0, 32'h0, 32'h0, 6'd1, 1, 0, 0, 1, 1),
                            1, 0, 32'h0, 32'h0, 32'h0, 6'd0, 0, 0, 0, 5'd0, 0);
        vecs[9]  = with_exp(mk_id(1, 1, 0, 3, 32'h0, 32'h0, 32'h1, 6'd1, 1, 1, 0, 0, 1),
                            0, 0, 32'h0, 32'h0, 32'h0, 6'd0, 0, 0, 0, 5'd0, 0);
        vecs[10] = with_exp(with_fwd(mk_id(1, 2, 5, 0, 32'h1000, 32'h1111, 32'h8, 6'd1, 1, 0, 0, 1, 0),
                                     1, 5, 32'hDEAD, 1, 5, 32'hBEEF),
                            0, 1, 32'h1000, 32'h8, 32'hDEAD, 6'd1, 0, 0, 1, 5'd0, 1);
        vecs[11] = with_exp(mk_id(0, 1, 2, 10, 32'h0, 32'h0, 32'h0, 6'd5, 0, 1, 1, 1, 0),
                            0, 0, 32'h0, 32'h0, 32'h0, 6'd5, 0, 0, 0, 5'd0, 0);
        vecs[12] = with_exp(mk_id(1, 0, 0, 9, 32'h300, 32'h0, 32'h0, 6'd1, 1, 1, 1, 0, 0),
                            0, 1, 32'h300, 32'h0, 32'h0, 6'd1, 1, 1, 0, 5'd9, 1);
        vecs[13] = with_exp(mk_id(1, 0, 9, 11, 32'h0, 32'h5, 32'h3, 6'd1, 1, 1, 0, 0, 0),
                            0, 1, 32'h0, 32'h3, 32'h5, 6'd1, 1, 0, 0, 5'd11, 1);
        vecs[14] = with_exp(mk_id(1, 0, 0, 12, 32'h400, 32'h0, 32'h0, 6'd1, 1, 1, 1, 0, 0),
                            0, 1, 32'h400, 32'h0, 32'h0, 6'd1, 1, 1, 0, 5'd12, 1);
        vecs[15] = with_exp(mk_id(1, 12, 0, 13, 32'h0, 32'h0, 32'h1, 6'd1, 1, 1, 0, 0, 0),
                            1, 0, 32'h0, 32'h0, 32'h0, 6'd0, 0, 0, 0, 5'd0, 0);
        vecs[16] = with_exp(with_fwd(mk_id(1, 12, 0, 13, 32'h0, 32'h0, 32'h1, 6'd1, 1, 1, 0, 0, 0),
                                     1, 12, 32'hABC, 0, 0, 32'h0),
                            0, 1, 32'hABC, 32'h1, 32'h0, 6'd1, 1, 0, 0, 5'd13, 1);

        // Reset held with an active instruction on the ID inputs
        rst = 1'b1;
        apply(vecs[4], 32'h80);
        repeat (2) @(posedge clk);
        #1;
        check("reset.ex_valid",     {31'd0, ex_valid},     32'd0);
        check("reset.alu_control",  {26'd0, alu_control},  32'd0);
        check("reset.stall_ifid",   {31'd0, stall_ifid},   32'd0);
        check("reset.ex_mem_read",  {31'd0, ex_mem_read},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            v = vecs[i];
            v.e_pc = 32'h1000 + 32'(i) * 4;
            apply(v, v.e_pc);
            sb.push_back(v);
            #1;
            check($sformatf("v%0d.stall_ifid", i), {31'd0, stall_ifid}, {31'd0, v.e_stall});
            @(posedge clk);
            #1;
            compare_ex($sformatf("v%0d", i));
        end

        // Asynchronous reset between edges clears a loaded EX stage at once
        @(negedge clk);
        apply(vecs[12], 32'h2000);
        @(posedge clk);
        #1;
        check("midrst.pre_valid", {31'd0, ex_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst.ex_valid",     {31'd0, ex_valid},     32'd0);
        check("midrst.ex_mem_read",  {31'd0, ex_mem_read},  32'd0);
        check("midrst.ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("midrst.alu_control",  {26'd0, alu_control},  32'd0);
        check("midrst.ex_pc",        ex_pc,                 32'd0);
        id_rs1_addr = 5'd9;
        #1;
        check("midrst.stall_ifid", {31'd0, stall_ifid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
